fsmc_buf_arbiter: RTL
=====================

Name: fsmc_buf_arbiter

Overview:
- Sequences and shares the single-port 512x16 FSMC buffer RAM between two requesters: the MCU host, which sends already-synchronized FSMC write/read events, and an FPGA-internal local requester.
- The host has absolute priority because FSMC has no wait line. The local port stalls through a req/gnt handshake.
- Owns the auto-incrementing host buffer pointer and a small status register. Sits between the FSMC edge detectors and the RAM.

Parameters:
- AW, 9, RAM address width; the pointer wraps at 2^AW.
- DW, 16, data width.

Ports:
- clk  in  1  system clock (PLL c0 domain)
- reset_l  in  1  asynchronous active-low reset (PLL locked)
- h_wr  in  1  one-cycle host write event, already synchronized and qualified by chip select
- h_rd  in  1  one-cycle host read event, already synchronized and qualified by chip select
- h_addr  in  2  host register select
- h_wdata  in  DW  host write data
- h_rdata  out  DW  registered host read data, driven to the FSMC bus by the top level
- h_ptr  out  AW  current host pointer (used for the LEDs)
- l_req  in  1  local request; held until granted
- l_we  in  1  local write (1) or read (0); valid while l_req is high
- l_addr  in  AW  local address
- l_wdata  in  DW  local write data
- l_gnt  out  1  one-cycle grant pulse
- l_rvalid  out  1  one-cycle local read-data valid
- l_rdata  out  DW  local read data
- m_en, m_we  out  1  RAM enable / write enable (registered)
- m_addr  out  AW  RAM address (registered)
- m_wdata  out  DW  RAM write data (registered)
- m_rdata  in  DW  RAM read data, valid in the cycle after m_en

Behaviour:
Reset:
- All outputs, h_ptr, status and pipeline flags are 0, asynchronously.
- In-flight read returns are discarded; no l_rvalid is issued after reset.

Host decode on an event sampled at edge E:
- h_wr with h_addr[1]=1: h_ptr <= h_wdata[AW-1:0]. No RAM access.
- h_wr with h_addr=00: RAM write at h_ptr; h_ptr increments.
- h_wr with h_addr=01: ignored.
- h_rd with h_addr=00: RAM read at h_ptr; h_ptr increments. h_rdata <= m_rdata at edge E+2.
- h_rd with h_addr=01: h_rdata <= status at E+1.
- h_rd with h_addr[1]=1: h_rdata <= zero-extended h_ptr at E+1.
- h_ptr wraps from 2^AW-1 to 0.

Arbitration at each edge, priority order:
1. A host RAM event owns the RAM for the next cycle.
2. Otherwise, l_req=1 with no local access outstanding: m_* <= local request and l_gnt=1 in the same cycle as m_en.
3. Otherwise m_en=0.

Local handshake:
- The requester drops or changes l_req only after seeing l_gnt.
- Local read: l_rvalid=1 and l_rdata=m_rdata registered, two cycles after l_gnt.
- Back-to-back local grants are allowed every cycle when no host event is present.

Simultaneous events:
- h_wr and h_rd together: the write is performed, the read is dropped, and sticky status[7] is set.
- A host event in the same cycle as l_req: the host wins and the local request is retried on the next free cycle.

Status word (16 bits):
- [15:8] starvation counter: cycles in which l_req=1 but the grant was denied by the host. Saturates at 255.
- [7] overlap error (sticky).
- [6:0] completed local accesses, modulo 128.
- A status read returns the pre-clear value, then clears [15:7].
- A starvation increment in the same cycle as the clear gives 1.

Optional Feature:
- Macro: FSMC_ARB_STATUS_EN.
- Defined: status register and counters as described above.
- Undefined: counters and the sticky error flag are not built. A host read with h_addr=01 returns 16'h0000. Arbitration and all other behaviour are unchanged.

Test Plan:
- Host write at h_addr=10 with data 16'h01FE, then host writes 16'hAAAA and 16'hBBBB at h_addr=00 -> RAM[510]=AAAA, RAM[511]=BBBB, h_ptr=0 (wrap).
- Set pointer to 5, then host read at h_addr=00 -> h_rdata equals RAM[5] at edge E+2 and h_ptr=6.
- l_req write to address 3 with no host traffic -> l_gnt in the next cycle, m_we=1, m_addr=3. A following local read of address 3 -> l_rvalid two cycles after its grant with the written data.
- h_wr (h_addr=00) in the same cycle as l_req -> host write issued first, l_gnt one cycle later; a status read then returns [15:8]=1.
- h_wr and h_rd asserted together -> write performed; status read returns bit7=1; a second status read returns bit7=0.
- reset_l pulled low one cycle after a local read grant -> l_rvalid never asserts; all outputs are 0 immediately (asynchronously).

Source files
------------

// File: rtl/fsmc_buf_arbiter_if.sv
// Bus bundle between the FSMC edge detectors / local requester and the buffer RAM.
// The arbiter uses the slave modport; the surrounding logic uses master.
interface fsmc_buf_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 16
);
  logic          h_wr;
  logic          h_rd;
  logic [1:0]    h_addr;
  logic [DW-1:0] h_wdata;
  logic [DW-1:0] h_rdata;
  logic [AW-1:0] h_ptr;
  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [DW-1:0] l_rdata;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  h_wr, h_rd, h_addr, h_wdata, l_req, l_we, l_addr, l_wdata, m_rdata,
    output h_rdata, h_ptr, l_gnt, l_rvalid, l_rdata, m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output h_wr, h_rd, h_addr, h_wdata, l_req, l_we, l_addr, l_wdata, m_rdata,
    input  h_rdata, h_ptr, l_gnt, l_rvalid, l_rdata, m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/fsmc_buf_arbiter.sv
// Shares the single-port FSMC buffer RAM between the host (absolute priority) and a local requester.
// Optional status register/counters are built only when FSMC_ARB_STATUS_EN is defined.
module fsmc_buf_arbiter #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic               clk,
  input  logic               reset_l,
  fsmc_buf_arbiter_if.slave  bus
);

  logic          host_rd_ok, host_ram_wr, host_ram_rd, host_ram, local_gnt;
  logic          ptr_wr, stat_rd, ptr_rd;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          m_en_q, m_en_d, m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          l_gnt_q;
  logic          hrd1_q, hrd2_q, lrd1_q, lrd2_q;
  logic          stat_rd_q, ptr_rd_q;
  logic          l_rvalid_q;
  logic [DW-1:0] l_rdata_q, l_rdata_d;
  logic [DW-1:0] h_rdata_q, h_rdata_d;
  logic [DW-1:0] status_w;

  // A simultaneous write wins; the colliding read is dropped.
  assign host_rd_ok  = bus.h_rd & ~bus.h_wr;
  assign host_ram_wr = bus.h_wr & (bus.h_addr == 2'b00);
  assign host_ram_rd = host_rd_ok & (bus.h_addr == 2'b00);
  assign host_ram    = host_ram_wr | host_ram_rd;
  assign ptr_wr      = bus.h_wr & bus.h_addr[1];
  assign stat_rd     = host_rd_ok & (bus.h_addr == 2'b01);
  assign ptr_rd      = host_rd_ok & bus.h_addr[1];
  // The requester updates l_req within the grant cycle, so every free cycle can be granted.
  assign local_gnt   = bus.l_req & ~host_ram;

  always_comb begin
    ptr_d     = ptr_q;
    m_en_d    = host_ram | local_gnt;
    m_we_d    = 1'b0;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    if (ptr_wr)
      ptr_d = bus.h_wdata[AW-1:0];
    else if (host_ram)
      ptr_d = ptr_q + 1'b1;
    if (host_ram) begin
      m_we_d    = host_ram_wr;
      m_addr_d  = ptr_q;
      m_wdata_d = bus.h_wdata;
    end else if (local_gnt) begin
      m_we_d    = bus.l_we;
      m_addr_d  = bus.l_addr;
      m_wdata_d = bus.l_wdata;
    end
  end

  always_comb begin
    h_rdata_d = h_rdata_q;
    l_rdata_d = l_rdata_q;
    if (hrd2_q)
      h_rdata_d = bus.m_rdata;
    else if (stat_rd_q)
      h_rdata_d = status_w;
    else if (ptr_rd_q)
      h_rdata_d = DW'(ptr_q);
    if (lrd2_q)
      l_rdata_d = bus.m_rdata;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      ptr_q      <= '0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      l_gnt_q    <= 1'b0;
      hrd1_q     <= 1'b0;
      hrd2_q     <= 1'b0;
      lrd1_q     <= 1'b0;
      lrd2_q     <= 1'b0;
      stat_rd_q  <= 1'b0;
      ptr_rd_q   <= 1'b0;
      l_rvalid_q <= 1'b0;
      l_rdata_q  <= '0;
      h_rdata_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      m_en_q     <= m_en_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      l_gnt_q    <= local_gnt;
      hrd1_q     <= host_ram_rd;
      hrd2_q     <= hrd1_q;
      lrd1_q     <= local_gnt & ~bus.l_we;
      lrd2_q     <= lrd1_q;
      stat_rd_q  <= stat_rd;
      ptr_rd_q   <= ptr_rd;
      l_rvalid_q <= lrd2_q;
      l_rdata_q  <= l_rdata_d;
      h_rdata_q  <= h_rdata_d;
    end
  end

`ifdef FSMC_ARB_STATUS_EN
  logic [7:0] starv_q, starv_d;
  logic       ovl_q, ovl_d;
  logic [6:0] done_q, done_d;
  logic       starv_inc;

  assign starv_inc = bus.l_req & host_ram;

  // The clear lands on the same edge that loads the pre-clear value into h_rdata.
  always_comb begin
    starv_d = starv_q;
    if (stat_rd_q)
      starv_d = {7'd0, starv_inc};
    else if (starv_inc && (starv_q != 8'hFF))
      starv_d = starv_q + 8'd1;
    ovl_d  = (bus.h_wr & bus.h_rd) | (ovl_q & ~stat_rd_q);
    done_d = done_q + 7'(local_gnt & bus.l_we) + 7'(lrd2_q);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      starv_q <= '0;
      ovl_q   <= 1'b0;
      done_q  <= '0;
    end else begin
      starv_q <= starv_d;
      ovl_q   <= ovl_d;
      done_q  <= done_d;
    end
  end

  assign status_w = DW'({starv_q, ovl_q, done_q});
`else
  assign status_w = '0;
`endif

  assign bus.h_rdata  = h_rdata_q;
  assign bus.h_ptr    = ptr_q;
  assign bus.l_gnt    = l_gnt_q;
  assign bus.l_rvalid = l_rvalid_q;
  assign bus.l_rdata  = l_rdata_q;
  assign bus.m_en     = m_en_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;

endmodule
